// File: rtl/gate_truth_checker.sv
// Stimulus/response checker for a 2-input combinational gate: walks vectors 11,10,01,00,
// samples the gate output after a programmable settle time and compares against TRUTH.
module gate_truth_checker #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       out,
  output logic       inp1,
  output logic       inp2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail,
  output logic       fail_seen
);

  localparam int unsigned CW = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    inp_q, inp_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [2:0]    err_q, err_d;
  logic [1:0]    ff_q, ff_d;
  logic          fs_q, fs_d;
  logic          mismatch_c;

  // X/Z on the gate output must count as a failure, hence case inequality
  assign mismatch_c = (out !== TRUTH[idx_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      inp_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      ff_q    <= 2'd0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      inp_q   <= inp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    inp_d   = inp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fs_d    = fs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = 2'd3;
          cnt_d   = '0;
          inp_d   = 2'b11;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          ff_d    = 2'd0;
          fs_d    = 1'b0;
        end
      end
      APPLY: begin
        if (cnt_q == CNT_LAST) begin
          if (mismatch_c) begin
            err_d = err_q + 3'd1;
            if (!fs_q) begin
              ff_d = idx_q;
              fs_d = 1'b1;
            end
          end
          if (idx_q != 2'd0) begin
            idx_d = idx_q - 2'd1;
            inp_d = idx_q - 2'd1;
            cnt_d = '0;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 3'd0);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign inp1       = inp_q[1];
  assign inp2       = inp_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_seen  = fs_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three configurations share start/rst, each drives a
// bench-modelled gate; a timeline model predicts every output on every cycle.
module tb_gate_truth_checker;

  localparam int N = 3;
  // instance 0: AND expected, SETTLE=2; 1: OR expected, SETTLE=2; 2: AND expected, SETTLE=0
  localparam logic [11:0] TTP = {4'b1000, 4'b1110, 4'b1000};
  localparam logic [11:0] STP = {4'd0, 4'd2, 4'd2};

  logic clk = 1'b0;
  logic rst, start;
  logic [N-1:0] inp1, inp2, busy, done, pass, fsn, gout;
  logic [2:0] errc [N];
  logic [1:0] ffv [N];
  logic [3:0] gtt [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign gout[g] = gtt[g][{inp1[g], inp2[g]}];
    gate_truth_checker #(.TRUTH(TTP[4*g +: 4]), .SETTLE(int'(STP[4*g +: 4]))) u_dut (
      .clk(clk), .rst(rst), .start(start), .out(gout[g]),
      .inp1(inp1[g]), .inp2(inp2[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .err_count(errc[g]), .first_fail(ffv[g]), .fail_seen(fsn[g])
    );
  end

  // Model: t = edges since the accepted start (-1 when idle); results from truth-table diff
  int t [N] = '{-1, -1, -1};
  int r_pass [N] = '{0, 0, 0};
  int r_err [N] = '{0, 0, 0};
  int r_ff [N] = '{0, 0, 0};
  int r_fs [N] = '{0, 0, 0};
  int p_pass [N], p_err [N], p_ff [N], p_fs [N];

  function automatic int per(int i);
    return int'(STP[4*i +: 4]) + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        t[i] = -1; r_pass[i] = 0; r_err[i] = 0; r_ff[i] = 0; r_fs[i] = 0;
      end else if (t[i] < 0) begin
        if (start) begin
          logic [3:0] diff;
          diff = gtt[i] ^ TTP[4*i +: 4];
          t[i] = 0; r_pass[i] = 0; r_err[i] = 0; r_ff[i] = 0; r_fs[i] = 0;
          p_err[i] = $countones(diff);
          p_pass[i] = (diff == 4'd0) ? 1 : 0;
          p_fs[i] = (diff != 4'd0) ? 1 : 0;
          p_ff[i] = 0;
          for (int b = 0; b < 4; b++) if (diff[b]) p_ff[i] = b;
        end
      end else begin
        t[i] = t[i] + 1;
        if (t[i] == 4 * per(i)) begin
          r_pass[i] = p_pass[i]; r_err[i] = p_err[i]; r_ff[i] = p_ff[i]; r_fs[i] = p_fs[i];
        end else if (t[i] > 4 * per(i)) begin
          t[i] = -1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int p;
      p = per(i);
      if (t[i] >= 0 && t[i] < 4 * p) begin
        chk("busy", i, busy[i], 1);
        chk("done", i, done[i], 0);
        chk("inp", i, {inp1[i], inp2[i]}, 3 - t[i] / p);
        chk("pass_run", i, pass[i], 0);
      end else begin
        chk("busy", i, busy[i], 0);
        chk("done", i, done[i], (t[i] == 4 * p) ? 1 : 0);
        chk("inp", i, {inp1[i], inp2[i]}, 0);
        chk("pass", i, pass[i], r_pass[i]);
        chk("err_count", i, errc[i], r_err[i]);
        chk("first_fail", i, ffv[i], r_ff[i]);
        chk("fail_seen", i, fsn[i], r_fs[i]);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int i, output int n);
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!done[i] && n < 200) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((t[0] >= 0 || t[1] >= 0 || t[2] >= 0) && k < 100) begin
      cyc();
      k++;
    end
    chk("idle_timeout", 0, (k < 100) ? 1 : 0, 1);
  endtask

  initial begin
    int n, dc;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) gtt[i] = 4'b1000;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_err", 0, errc[0], 0);
    chk("rst_fs", 0, fsn[0], 0);

    // AND gate on all instances
    run(0, n);
    chk("lat_s2", 0, n, 12);
    chk("and_pass", 0, pass[0], 1);
    chk("and_err", 0, errc[0], 0);
    chk("or_exp_err", 1, errc[1], 2);
    chk("or_exp_ff", 1, ffv[1], 2);
    chk("or_exp_pass", 1, pass[1], 0);
    wait_idle();

    // SETTLE=0 then a back-to-back start right after DONE
    run(2, n);
    chk("lat_s0", 2, n, 4);
    chk("s0_pass", 2, pass[2], 1);
    cyc();
    run(2, n);
    chk("b2b_lat", 2, n, 4);
    chk("b2b_pass", 2, pass[2], 1);
    wait_idle();

    // stuck-at-0 gate
    for (int i = 0; i < N; i++) gtt[i] = 4'b0000;
    run(0, n);
    chk("sa0_err", 0, errc[0], 1);
    chk("sa0_ff", 0, ffv[0], 3);
    chk("sa0_fs", 0, fsn[0], 1);
    chk("sa0_pass", 0, pass[0], 0);
    wait_idle();

    // starts during a run are ignored
    for (int i = 0; i < N; i++) gtt[i] = 4'b1000;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    dc = 0;
    repeat (12) begin cyc(); dc += int'(done[0]); end
    chk("single_done", 0, dc, 1);
    wait_idle();

    // reset mid-run
    start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 0, busy[0], 0);
    chk("midrst_inp", 0, {inp1[0], inp2[0]}, 0);
    cyc();
    rst = 1'b0;
    cyc();
    run(0, n);
    chk("post_rst_lat", 0, n, 12);
    chk("post_rst_pass", 0, pass[0], 1);
    wait_idle();

    // randomized gates, starts and resets
    for (int k = 0; k < 60; k++) begin
      if (t[0] < 0 && t[1] < 0 && t[2] < 0)
        for (int i = 0; i < N; i++)
          gtt[i] = ($urandom_range(0, 2) == 0) ? TTP[4*i +: 4] : 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; cyc(); rst = 1'b0;
      end
      start = ($urandom_range(0, 2) == 0);
      cyc();
      start = 1'b0;
      repeat ($urandom_range(0, 14)) cyc();
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
